mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port RAM.
// Port 0 is the processor, port 1 the DMA/loader. One access is in flight at a
// time: IDLE samples requests, ACCESS issues the RAM command and grants, and
// RDATA returns read data to the winner before going back to IDLE.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  // requester 0 (processor)
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  // requester 1 (DMA / loader)
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  // RAM command / response
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  // status
  output logic          busy,
  output logic [7:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_last_gnt;     // port granted most recently (tie breaker)
  logic            r_winner;       // port owning the transaction in flight
  logic            r_we;           // registered command direction
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [7:0]      r_conflict_cnt;

  logic            w_any_req;
  logic            w_both_req;
  logic            w_sample;       // an arbitration happens at this edge
  logic            w_winner;

  // Round-robin pick: a lone requester wins, a tie goes to the port that did
  // not win last time.
  always_comb begin
    w_any_req  = p0_req | p1_req;
    w_both_req = p0_req & p1_req;
    w_sample   = (r_state == IDLE) && w_any_req;
    if (w_both_req) begin
      w_winner = ~r_last_gnt;
    end else begin
      w_winner = p1_req;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode; outputs follow the state directly so that
  // reset clears them without waiting for a clock edge.
  always_comb begin
    w_state_next = r_state;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    p0_rvalid    = 1'b0;
    p1_rvalid    = 1'b0;
    p0_rdata     = '0;
    p1_rdata     = '0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_en = 1'b1;
        ram_we = r_we;
        p0_gnt = ~r_winner;
        p1_gnt = r_winner;
        w_state_next = r_we ? IDLE : RDATA;
      end
      RDATA: begin
        // RAM data for the read issued in ACCESS arrives in this cycle.
        if (r_winner) begin
          p1_rvalid = 1'b1;
          p1_rdata  = ram_rdata;
        end else begin
          p0_rvalid = 1'b1;
          p0_rdata  = ram_rdata;
        end
        w_state_next = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture the winner's command at the arbitration edge; address and write
  // data then hold until the next arbitration.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_last_gnt <= 1'b1;
      r_winner   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_sample) begin
      r_last_gnt <= w_winner;
      r_winner   <= w_winner;
      r_we       <= w_winner ? p1_we    : p0_we;
      r_addr     <= w_winner ? p1_addr  : p0_addr;
      r_wdata    <= w_winner ? p1_wdata : p0_wdata;
    end
  end

  // Count arbitration edges that saw both ports requesting; sticks at 255.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_conflict_cnt <= 8'd0;
    end else if ((r_state == IDLE) && w_both_req && (r_conflict_cnt != 8'hFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule
